// File: rtl/img_pkg.sv
// Shared image geometry defaults, coordinate widths and FSM encoding for the window generator.
package img_pkg;

    localparam int unsigned IMG_W_DEF  = 224;
    localparam int unsigned IMG_H_DEF  = 224;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned X_W        = 10;
    localparam int unsigned Y_W        = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } state_e;

endpackage

// File: rtl/line_ram_sdp.sv
// Simple dual-port line RAM: one write port, one synchronous read-first read port.
module line_ram_sdp #(
    parameter int unsigned Depth = 224,
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Read-first: a same-address write in this cycle is not visible to this read.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood generator: two line buffers, column shift registers and a
// two-stage valid/coordinate pipeline emitting one window per interior pixel.
module window_gen_3x3
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic                i_sof,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_valid,
    output logic [9*DATA_W-1:0] o_win,
    output logic [X_W-1:0]      o_cx,
    output logic [Y_W-1:0]      o_cy,
    output logic                o_eof
);

    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [X_W-1:0] ColLast = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] RowLast = Y_W'(IMG_H - 1);

    state_e         state_q;
    logic [X_W-1:0] col_q;
    logic [Y_W-1:0] row_q;

    logic           sof;
    logic           take;
    logic           emit;
    logic [X_W-1:0] cur_col;
    logic [Y_W-1:0] cur_row;

    // A start-of-frame pixel overrides the counters and is always (0,0).
    assign sof     = i_valid & i_sof;
    assign take    = i_valid & (i_sof | (state_q != StIdle));
    assign cur_col = sof ? '0 : col_q;
    assign cur_row = sof ? '0 : row_q;
    assign emit    = take & ~sof & (state_q == StRun) & (cur_col >= X_W'(2));

    // Frame FSM and raster counters; only accepted pixels advance them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
        end else if (take) begin
            if (cur_col == ColLast) begin
                col_q <= '0;
                if (cur_row == RowLast) begin
                    row_q   <= '0;
                    state_q <= StIdle;
                end else begin
                    row_q   <= cur_row + Y_W'(1);
                    state_q <= (cur_row >= Y_W'(1)) ? StRun : StFill;
                end
            end else begin
                col_q   <= cur_col + X_W'(1);
                row_q   <= cur_row;
                state_q <= (cur_row >= Y_W'(2)) ? StRun : StFill;
            end
        end
    end

    // Stage 1 (line RAM read in flight)
    logic              s1_take_q;
    logic              s1_emit_q;
    logic [AW-1:0]     s1_addr_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [X_W-1:0]    s1_cx_q;
    logic [Y_W-1:0]    s1_cy_q;
    logic              s1_eof_q;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;

    // LB1 holds row y-1: written with the incoming pixel.
    line_ram_sdp #(
        .Depth (IMG_W),
        .Width (DATA_W),
        .AddrW (AW)
    ) u_lb1 (
        .clk_i   (i_clk),
        .we_i    (take),
        .waddr_i (cur_col[AW-1:0]),
        .wdata_i (i_data),
        .re_i    (take),
        .raddr_i (cur_col[AW-1:0]),
        .rdata_o (lb1_rd)
    );

    // LB2 holds row y-2: the old LB1 word is only available one cycle later,
    // so its write trails by a cycle; the next read of that column is a row away.
    line_ram_sdp #(
        .Depth (IMG_W),
        .Width (DATA_W),
        .AddrW (AW)
    ) u_lb2 (
        .clk_i   (i_clk),
        .we_i    (s1_take_q),
        .waddr_i (s1_addr_q),
        .wdata_i (lb1_rd),
        .re_i    (take),
        .raddr_i (cur_col[AW-1:0]),
        .rdata_o (lb2_rd)
    );

    // Stage 1 registers: accepted pixel, its column and the window it would complete.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_take_q <= 1'b0;
            s1_emit_q <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
            s1_cx_q   <= '0;
            s1_cy_q   <= '0;
            s1_eof_q  <= 1'b0;
        end else begin
            s1_take_q <= take;
            s1_emit_q <= emit;
            if (take) begin
                s1_addr_q <= cur_col[AW-1:0];
                s1_data_q <= i_data;
                s1_cx_q   <= cur_col - X_W'(1);
                s1_cy_q   <= cur_row - Y_W'(1);
                s1_eof_q  <= (cur_col == ColLast) && (cur_row == RowLast);
            end
        end
    end

    // Column shift registers: index 0 is the leftmost (oldest) column.
    logic [DATA_W-1:0] top_q [3];
    logic [DATA_W-1:0] mid_q [3];
    logic [DATA_W-1:0] bot_q [3];

    // Shift in one column per accepted pixel once its line RAM words arrive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
        end else if (s1_take_q) begin
            top_q[0] <= top_q[1];
            top_q[1] <= top_q[2];
            top_q[2] <= lb2_rd;
            mid_q[0] <= mid_q[1];
            mid_q[1] <= mid_q[2];
            mid_q[2] <= lb1_rd;
            bot_q[0] <= bot_q[1];
            bot_q[1] <= bot_q[2];
            bot_q[2] <= s1_data_q;
        end
    end

    // Stage 2 registers: window is complete in the shift registers.
    logic           s2_valid_q;
    logic [X_W-1:0] s2_cx_q;
    logic [Y_W-1:0] s2_cy_q;
    logic           s2_eof_q;

    // Carry the emit flag and coordinates alongside the shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_cx_q    <= '0;
            s2_cy_q    <= '0;
            s2_eof_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_take_q & s1_emit_q;
            if (s1_take_q && s1_emit_q) begin
                s2_cx_q  <= s1_cx_q;
                s2_cy_q  <= s1_cy_q;
                s2_eof_q <= s1_eof_q;
            end
        end
    end

    logic                o_valid_q;
    logic [9*DATA_W-1:0] o_win_q;
    logic [X_W-1:0]      o_cx_q;
    logic [Y_W-1:0]      o_cy_q;
    logic                o_eof_q;

    // Output registers: window/coordinates hold between pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_win_q   <= '0;
            o_cx_q    <= '0;
            o_cy_q    <= '0;
            o_eof_q   <= 1'b0;
        end else begin
            o_valid_q <= s2_valid_q;
            o_eof_q   <= s2_valid_q & s2_eof_q;
            if (s2_valid_q) begin
                o_win_q <= {top_q[0], top_q[1], top_q[2],
                            mid_q[0], mid_q[1], mid_q[2],
                            bot_q[0], bot_q[1], bot_q[2]};
                o_cx_q  <= s2_cx_q;
                o_cy_q  <= s2_cy_q;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_win   = o_win_q;
    assign o_cx    = o_cx_q;
    assign o_cy    = o_cy_q;
    assign o_eof   = o_eof_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench: 4x4 instance for frame/latency/restart/reset cases, 6x5 instance for
// back-to-back frames. Pixel value = base + 16*y + x.
module tb_window_gen_3x3;

    localparam int W2 = 6;
    localparam int H2 = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        v     = 1'b0;
    logic        sof   = 1'b0;
    logic [7:0]  d     = '0;
    logic        ov;
    logic [71:0] ow;
    logic [9:0]  ocx;
    logic [8:0]  ocy;
    logic        oeof;

    logic        v2   = 1'b0;
    logic        sof2 = 1'b0;
    logic [7:0]  d2   = '0;
    logic        ov2;
    logic [71:0] ow2;
    logic [9:0]  ocx2;
    logic [8:0]  ocy2;
    logic        oeof2;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int last_acc = 0;

    int          m_edge[$];
    logic [71:0] m_win[$];
    int          m_cx[$];
    int          m_cy[$];
    logic        m_eof[$];
    int          exp_edge[$];

    logic [71:0] n_win[$];
    int          n_cx[$];
    int          n_cy[$];
    logic        n_eof[$];

    window_gen_3x3 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v),
        .i_sof   (sof),
        .i_data  (d),
        .o_valid (ov),
        .o_win   (ow),
        .o_cx    (ocx),
        .o_cy    (ocy),
        .o_eof   (oeof)
    );

    window_gen_3x3 #(.IMG_W(W2), .IMG_H(H2), .DATA_W(8)) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v2),
        .i_sof   (sof2),
        .i_data  (d2),
        .o_valid (ov2),
        .o_win   (ow2),
        .o_cx    (ocx2),
        .o_cy    (ocy2),
        .o_eof   (oeof2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Record every output window, sampled 1ns after the edge.
    always @(posedge clk) begin
        #1;
        if (ov === 1'b1) begin
            m_edge.push_back(edge_cnt);
            m_win.push_back(ow);
            m_cx.push_back(int'(ocx));
            m_cy.push_back(int'(ocy));
            m_eof.push_back(oeof);
        end
        if (ov2 === 1'b1) begin
            n_win.push_back(ow2);
            n_cx.push_back(int'(ocx2));
            n_cy.push_back(int'(ocy2));
            n_eof.push_back(oeof2);
        end
    end

    function automatic logic [71:0] exp_win(input int b, input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int r = -1; r <= 1; r++) begin
            for (int c = -1; c <= 1; c++) begin
                w = {w[63:0], 8'(b + 16 * (cy + r) + cx + c)};
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic idle(input int n);
        v = 1'b0;
        sof = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic px(input logic [7:0] dat, input logic s, input int gap);
        v = 1'b1;
        d = dat;
        sof = s;
        @(posedge clk);
        #1;
        last_acc = edge_cnt;
        v = 1'b0;
        sof = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int b, input int maxgap);
        int g;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                px(8'(b + 16 * y + x), (x == 0 && y == 0), g);
                if (x >= 2 && y >= 2) exp_edge.push_back(last_acc);
            end
        end
    endtask

    task automatic clear_mon();
        m_edge.delete();
        m_win.delete();
        m_cx.delete();
        m_cy.delete();
        m_eof.delete();
        exp_edge.delete();
    endtask

    task automatic check_frame(input string t, input int b);
        int cx;
        int cy;
        idle(6);
        chk({t, " count"}, 72'(m_win.size()), 72'd4);
        for (int k = 0; k < 4 && k < m_win.size(); k++) begin
            cx = 1 + k % 2;
            cy = 1 + k / 2;
            chk($sformatf("%s win%0d", t, k), m_win[k], exp_win(b, cx, cy));
            chk($sformatf("%s cx%0d", t, k), 72'(m_cx[k]), 72'(cx));
            chk($sformatf("%s cy%0d", t, k), 72'(m_cy[k]), 72'(cy));
            chk($sformatf("%s eof%0d", t, k), 72'(m_eof[k]), 72'(k == 3));
            if (k < exp_edge.size()) begin
                chk($sformatf("%s latency%0d", t, k), 72'(m_edge[k]), 72'(exp_edge[k] + 2));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset o_valid", 72'(ov), 72'd0);
        chk("reset o_win", ow, 72'd0);
        chk("reset o_cx", 72'(ocx), 72'd0);
        chk("reset o_cy", 72'(ocy), 72'd0);
        chk("reset o_eof", 72'(oeof), 72'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: continuous frame, hand-computed first and last windows
        send_frame(0, 0);
        check_frame("t1", 0);
        if (m_win.size() == 4) begin
            chk("t1 first literal", m_win[0], 72'h00_01_02_10_11_12_20_21_22);
            chk("t1 last literal", m_win[3], 72'h11_12_13_21_22_23_31_32_33);
        end
        clear_mon();

        // 2: random idle gaps between pixels
        send_frame(0, 3);
        check_frame("t2", 0);
        clear_mon();

        // 3: pixels before any sof are discarded
        for (int i = 0; i < 6; i++) px(8'(i + 8'h50), 1'b0, 0);
        idle(6);
        chk("t3 no sof count", 72'(m_win.size()), 72'd0);
        send_frame(0, 0);
        check_frame("t3", 0);
        clear_mon();

        // 4: frame A cut short by sof at position (1,2), then frame B
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) px(8'(16 * y + x), (x == 0 && y == 0), 0);
        end
        px(8'h20, 1'b0, 0);
        send_frame(8'h80, 0);
        check_frame("t4", 8'h80);
        clear_mon();

        // 5: reset pulse mid-RUN while a window is on the outputs
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) px(8'(16 * y + x), (x == 0 && y == 0), 0);
        end
        idle(1);
        chk("t5 pre-reset valid", 72'(ov), 72'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 rst o_valid", 72'(ov), 72'd0);
        chk("t5 rst o_win", ow, 72'd0);
        chk("t5 rst o_cx", 72'(ocx), 72'd0);
        chk("t5 rst o_cy", 72'(ocy), 72'd0);
        chk("t5 rst o_eof", 72'(oeof), 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        idle(1);
        for (int x = 0; x < 4; x++) px(8'(8'h30 + x), 1'b0, 0);
        idle(6);
        chk("t5 flushed count", 72'(m_win.size()), 72'd0);
        send_frame(8'h40, 0);
        check_frame("t5", 8'h40);
        clear_mon();

        // 6: 6x5 instance, two back-to-back frames
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < H2; y++) begin
                for (int x = 0; x < W2; x++) begin
                    v2 = 1'b1;
                    d2 = 8'(128 * f + 16 * y + x);
                    sof2 = (x == 0 && y == 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        v2 = 1'b0;
        sof2 = 1'b0;
        idle(6);
        chk("t6 count", 72'(n_win.size()), 72'd24);
        for (int k = 0; k < 24 && k < n_win.size(); k++) begin
            int j;
            j = k % 12;
            chk($sformatf("t6 win%0d", k), n_win[k], exp_win(128 * (k / 12), 1 + j % 4, 1 + j / 4));
            chk($sformatf("t6 cx%0d", k), 72'(n_cx[k]), 72'(1 + j % 4));
            chk($sformatf("t6 cy%0d", k), 72'(n_cy[k]), 72'(1 + j / 4));
            chk($sformatf("t6 eof%0d", k), 72'(n_eof[k]), 72'(j == 11));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
